// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 core: default bus widths and the
// response-owner encoding used by the instruction/data memory arbiter.
package jedro_1_defines;

    localparam int unsigned JEDRO_1_ADDR_WIDTH = 32;
    localparam int unsigned JEDRO_1_DATA_WIDTH = 32;

    // Which port owns the RAM read data arriving this cycle.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } resp_e;

endpackage : jedro_1_defines

// File: rtl/jedro_1_mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port
// byte-write RAM. Grants are combinational; data wins contention except after
// MAX_STREAK consecutive contended data grants, which hands one slot to fetch.
// Read data returns one cycle after the grant to whichever port owned it.
module jedro_1_mem_arbiter
    import jedro_1_defines::*;
#(
    parameter int unsigned ADDR_WIDTH = JEDRO_1_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = JEDRO_1_DATA_WIDTH,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    ireq_i,
    input  logic [ADDR_WIDTH-1:0]   iaddr_i,
    output logic                    igrant_o,
    output logic                    irvalid_o,
    output logic [DATA_WIDTH-1:0]   irdata_o,

    input  logic                    dreq_i,
    input  logic [DATA_WIDTH/8-1:0] dwe_i,
    input  logic [ADDR_WIDTH-1:0]   daddr_i,
    input  logic [DATA_WIDTH-1:0]   dwdata_i,
    output logic                    dgrant_o,
    output logic                    drvalid_o,
    output logic [DATA_WIDTH-1:0]   drdata_o,

    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_cnt;
    logic [STREAK_W-1:0] streak_next;
    logic                streak_full;
    resp_e               resp_q;
    resp_e               resp_next;

    assign streak_full = (streak_cnt == STREAK_W'(MAX_STREAK));

    // Grant selection: data wins contention until the streak saturates; no grants in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        igrant_o = 1'b0;
        dgrant_o = 1'b0;
        if (rstn_i) begin
            if (dreq_i && !(ireq_i && streak_full)) begin
                dgrant_o = 1'b1;
            end else if (ireq_i) begin
                igrant_o = 1'b1;
            end
        end
    end

    // RAM request mux: follow the granted port, all zero when idle; fetches never write.
    always_comb begin
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (dgrant_o) begin
            mem_we_o    = dwe_i;
            mem_addr_o  = daddr_i;
            mem_wdata_o = dwdata_i;
        end else if (igrant_o) begin
            mem_addr_o  = iaddr_i;
        end
    end

    assign mem_en_o = igrant_o | dgrant_o;

    // Next streak count and next response owner, both derived from this cycle's grant.
    always_comb begin
        streak_next = streak_cnt;
        resp_next   = NONE;
        if (!ireq_i || igrant_o) begin
            streak_next = '0;
        end else if (dgrant_o && !streak_full) begin
            streak_next = streak_cnt + STREAK_W'(1);
        end
        if (igrant_o) begin
            resp_next = INSTR;
        end else if (dgrant_o) begin
            resp_next = DATA;
        end
    end

    // State register; asynchronous reset drops any pending response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            streak_cnt <= '0;
            resp_q     <= NONE;
        end else begin
            streak_cnt <= streak_next;
            resp_q     <= resp_next;
        end
    end

    assign irvalid_o = (resp_q == INSTR);
    assign drvalid_o = (resp_q == DATA);
    assign irdata_o  = irvalid_o ? mem_rdata_i : '0;
    assign drdata_o  = drvalid_o ? mem_rdata_i : '0;

endmodule : jedro_1_mem_arbiter
